keypad_code_entry: RTL and testbench
====================================

Name: keypad_code_entry

Overview:
- Scans a 4x4 matrix keypad and debounces key presses.
- Assembles the user's two-digit item code as two BCD nibbles and hands it to the vending controller with a valid/ack handshake.
- Input-side counterpart of the multiplexed 2-digit code display: code_out feeds the display's 8-bit code input directly. code_out[7:4] is the first (tens) digit; code_out[3:0] is the second (units) digit.

Parameters:
SCAN_DIV, 50000, clock cycles each column is driven before its rows are sampled (>=2)
DEBOUNCE, 4, consecutive identical scan frames required to accept a press or a release (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
row_in  input  4  keypad rows, active-low (external pull-ups); row_in[r] = row r
col_select  output  4  keypad column drive, active-low one-hot; col_select[c] = column c
code_ack  input  1  controller has consumed code_out; meaningful only while code_valid=1
code_out  output  8  entered code, {tens BCD, units BCD}
digit_count  output  2  digits currently entered (0, 1 or 2)
code_valid  output  1  high from enter until code_ack
key_pressed  output  1  one-cycle pulse per accepted debounced press (any key, any state; used for beeper)

Behaviour:
- Reset values: col_select=4'b1110, code_out=8'h00, digit_count=0, code_valid=0, key_pressed=0. Divider, column index, frame accumulator and debounce state are all cleared.
- Reset mid-scan or mid-entry returns everything to the reset values at the next edge. No partial press survives.
- Key map (row,col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - '*' = clear, '#' = enter, A-D = no function.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - On the cycle where the divider = SCAN_DIV-1: sample row_in for the active column, then rotate to the next column (3 wraps to 0).
  - One frame = 4*SCAN_DIV cycles. The frame ends at the column-3 sample.
- Frame result:
  - Exactly one asserted (low) row/column intersection in the frame gives that key.
  - Zero intersections gives NONE.
  - Two or more intersections (ghosting/multi-press) gives NONE.
- Debounce:
  - Each frame result is compared with the previous one. The run counter increments if they match, else it reloads to 1.
  - Press is accepted when the result is a key, the run reaches DEBOUNCE, and the key is not already latched. The key is then latched.
  - Latch clears after DEBOUNCE consecutive NONE frames.
  - A held key produces exactly one press.
  - A key change without an intervening release is not accepted until release.
- Latency:
  - key_pressed pulses the cycle after the frame-end sample that completes debounce.
  - The entry FSM update is visible in the same cycle as the pulse.
- Entry FSM (state reflected in digit_count/code_valid):
  - EMPTY:
    - digit d -> ONE, code_out={4'h0,d}
    - '*', '#', A-D -> no change
  - ONE:
    - digit d -> FULL, code_out={code_out[3:0],d}
    - '*' -> EMPTY, code_out=8'h00
    - '#', A-D ignored
  - FULL:
    - '#' -> DONE, code_valid=1
    - '*' -> EMPTY, code_out=0
    - digits and A-D ignored (no overwrite)
  - DONE:
    - all keys ignored, including '*'; key_pressed still pulses
    - code_ack -> EMPTY, code_out=0, digit_count=0, code_valid=0 on the next cycle
- Handshake:
  - code_valid is a level, held until acked.
  - code_out is stable while code_valid=1.
  - code_ack outside DONE is ignored.
  - code_ack and an accepted press in the same cycle while in DONE: ack wins, the press is discarded and not applied in EMPTY.
- digit_count: EMPTY=0, ONE=1, FULL/DONE=2.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE=3 (frame = 16 cycles).
1. Reset, then hold '4' (row_in=4'b1101 while col_select=4'b1110) for 6 frames -> one key_pressed pulse ~3 frames in, code_out=8'h04, digit_count=1. Release 3 frames, hold '2' -> code_out=8'h42, digit_count=2.
2. From 8'h42, press '#' -> code_valid=1. Press '7' -> key_pressed pulses, code_out stays 8'h42. Assert code_ack 1 cycle -> next cycle code_valid=0, code_out=8'h00, digit_count=0.
3. Bounce: '5' asserted alternating frames for 10 frames -> no key_pressed, code_out unchanged. Hold '5' for 20 frames -> exactly one pulse.
4. Press '1' and '2' simultaneously for 6 frames -> no press accepted. Enter '9', then '*' -> code_out=8'h00, digit_count=0. With 2 digits entered, a third digit is ignored.
5. code_ack coincident with an accepted '3' press in DONE -> state EMPTY, code_out=8'h00 (the '3' is not entered). code_ack in EMPTY -> no effect.
6. Assert reset mid-debounce of '6' and mid-FULL -> all outputs return to reset values next edge. '6' must complete a full debounce to be accepted after reset.

Source files
------------

// File: rtl/keypad_code_entry.sv
// 4x4 matrix keypad scanner with frame-based debounce and a two-digit BCD
// code entry FSM that hands the code to the vending controller via valid/ack.
module keypad_code_entry #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_select,
  input  logic       code_ack,
  output logic [7:0] code_out,
  output logic [1:0] digit_count,
  output logic       code_valid,
  output logic       key_pressed
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int RW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1);
  localparam logic [RW-1:0] RUN_MAX  = RW'(DEBOUNCE);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2, S_DONE = 2'd3} state_t;

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    col_sel_q, col_sel_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    key_q, key_d;
  logic [4:0]    prev_q, prev_d;
  logic [RW-1:0] run_q, run_d;
  logic          latched_q, latched_d;
  logic          press_q, press_d;
  state_t        state_q, state_d;
  logic [7:0]    code_q, code_d;

  logic          sample_s, frame_end_s;
  logic [3:0]    hit_s;
  logic [2:0]    cnt_s, sum_s;
  logic [4:0]    res_s;
  logic [6:0]    info_s;

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  function automatic logic [1:0] first_row(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Returns {is_digit, is_clear, is_enter, digit} for key index {row, col}.
  function automatic logic [6:0] key_info(input logic [3:0] k);
    case (k)
      4'd0:    return {3'b100, 4'h1};
      4'd1:    return {3'b100, 4'h2};
      4'd2:    return {3'b100, 4'h3};
      4'd4:    return {3'b100, 4'h4};
      4'd5:    return {3'b100, 4'h5};
      4'd6:    return {3'b100, 4'h6};
      4'd8:    return {3'b100, 4'h7};
      4'd9:    return {3'b100, 4'h8};
      4'd10:   return {3'b100, 4'h9};
      4'd12:   return {3'b010, 4'h0};
      4'd13:   return {3'b100, 4'h0};
      4'd14:   return {3'b001, 4'h0};
      default: return {3'b000, 4'h0};
    endcase
  endfunction

  assign sample_s    = (div_q == DIV_LAST);
  assign frame_end_s = sample_s && (col_q == 2'd3);
  assign hit_s       = ~row_in;
  assign cnt_s       = pop4(hit_s);
  assign sum_s       = {1'b0, hits_q} + cnt_s;

  // Divider, column rotation and per-frame intersection accumulator.
  always_comb begin
    div_d     = div_q + DIV_ONE;
    col_d     = col_q;
    col_sel_d = col_sel_q;
    hits_d    = hits_q;
    key_d     = key_q;
    res_s     = 5'b0_0000;
    if (sample_s) begin
      div_d     = '0;
      col_d     = col_q + 2'd1;
      col_sel_d = {col_sel_q[2:0], col_sel_q[3]};
      if (frame_end_s) begin
        hits_d = 2'd0;
        key_d  = 4'd0;
        if (sum_s == 3'd1) begin
          res_s = (hits_q == 2'd0) ? {1'b1, first_row(hit_s), col_q} : {1'b1, key_q};
        end else begin
          res_s = 5'b0_0000;
        end
      end else begin
        hits_d = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
        if (hits_q == 2'd0 && cnt_s == 3'd1) begin
          key_d = {first_row(hit_s), col_q};
        end else begin
          key_d = key_q;
        end
      end
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  // Run-length debounce; the latch makes a held or changed key yield one press until released.
  always_comb begin
    prev_d    = prev_q;
    run_d     = run_q;
    latched_d = latched_q;
    press_d   = 1'b0;
    if (frame_end_s) begin
      prev_d = res_s;
      if (res_s == prev_q) begin
        run_d = (run_q >= RUN_MAX) ? run_q : run_q + RUN_ONE;
      end else begin
        run_d = RUN_ONE;
      end
      if (res_s[4] && run_d == RUN_MAX && !latched_q) begin
        press_d   = 1'b1;
        latched_d = 1'b1;
      end else if (!res_s[4] && run_d == RUN_MAX) begin
        latched_d = 1'b0;
      end else begin
        latched_d = latched_q;
      end
    end else begin
      press_d = 1'b0;
    end
  end

  assign info_s = key_info(prev_d[3:0]);

  // Entry FSM next state; in DONE an ack takes priority and any coincident press is dropped.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_EMPTY: begin
        if (press_d && info_s[6]) begin
          state_d = S_ONE;
          code_d  = {4'h0, info_s[3:0]};
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_ONE: begin
        if (press_d && info_s[6]) begin
          state_d = S_FULL;
          code_d  = {code_q[3:0], info_s[3:0]};
        end else if (press_d && info_s[5]) begin
          state_d = S_EMPTY;
          code_d  = 8'h00;
        end else begin
          state_d = S_ONE;
        end
      end
      S_FULL: begin
        if (press_d && info_s[4]) begin
          state_d = S_DONE;
        end else if (press_d && info_s[5]) begin
          state_d = S_EMPTY;
          code_d  = 8'h00;
        end else begin
          state_d = S_FULL;
        end
      end
      S_DONE: begin
        if (code_ack) begin
          state_d = S_EMPTY;
          code_d  = 8'h00;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_EMPTY;
        code_d  = 8'h00;
      end
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    code_out    = code_q;
    key_pressed = press_q;
    col_select  = col_sel_q;
    case (state_q)
      S_EMPTY: begin digit_count = 2'd0; code_valid = 1'b0; end
      S_ONE:   begin digit_count = 2'd1; code_valid = 1'b0; end
      S_FULL:  begin digit_count = 2'd2; code_valid = 1'b0; end
      S_DONE:  begin digit_count = 2'd2; code_valid = 1'b1; end
      default: begin digit_count = 2'd0; code_valid = 1'b0; end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      col_q     <= 2'd0;
      col_sel_q <= 4'b1110;
      hits_q    <= 2'd0;
      key_q     <= 4'd0;
      prev_q    <= 5'b0_0000;
      run_q     <= '0;
      latched_q <= 1'b0;
      press_q   <= 1'b0;
      state_q   <= S_EMPTY;
      code_q    <= 8'h00;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      col_sel_q <= col_sel_d;
      hits_q    <= hits_d;
      key_q     <= key_d;
      prev_q    <= prev_d;
      run_q     <= run_d;
      latched_q <= latched_d;
      press_q   <= press_d;
      state_q   <= state_d;
      code_q    <= code_d;
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// Directed bench for keypad_code_entry: a keypad model drives row_in from the
// pressed-key mask and the active column; stimulus is aligned to 16-cycle frames.
module tb_keypad_code_entry;

  localparam int FRAME = 16;

  localparam logic [15:0] K_NONE = 16'h0000;
  localparam logic [15:0] K_1    = 16'h0001;
  localparam logic [15:0] K_2    = 16'h0002;
  localparam logic [15:0] K_3    = 16'h0004;
  localparam logic [15:0] K_A    = 16'h0008;
  localparam logic [15:0] K_4    = 16'h0010;
  localparam logic [15:0] K_5    = 16'h0020;
  localparam logic [15:0] K_6    = 16'h0040;
  localparam logic [15:0] K_7    = 16'h0100;
  localparam logic [15:0] K_8    = 16'h0200;
  localparam logic [15:0] K_9    = 16'h0400;
  localparam logic [15:0] K_STAR = 16'h1000;
  localparam logic [15:0] K_0    = 16'h2000;
  localparam logic [15:0] K_HASH = 16'h4000;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_select;
  logic       code_ack;
  logic [7:0] code_out;
  logic [1:0] digit_count;
  logic       code_valid;
  logic       key_pressed;
  logic [15:0] keys;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic [15:0] keys;
    int          frames;
    int          exp_pulses;
    logic [7:0]  exp_code;
    logic [1:0]  exp_dc;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  keypad_code_entry #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk(clk), .reset(reset), .row_in(row_in), .col_select(col_select),
    .code_ack(code_ack), .code_out(code_out), .digit_count(digit_count),
    .code_valid(code_valid), .key_pressed(key_pressed)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~|(keys[r*4 +: 4] & ~col_select);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (key_pressed === 1'b1) pulses++;
    end
  endtask

  task automatic add(input string nm, input logic [15:0] k, input int fr, input int p,
                     input logic [7:0] c, input logic [1:0] dc, input logic v);
    vec_t t;
    t.name = nm; t.keys = k; t.frames = fr; t.exp_pulses = p;
    t.exp_code = c; t.exp_dc = dc; t.exp_valid = v;
    vecs.push_back(t);
  endtask

  task automatic run_table(input int lo, input int hi);
    int p;
    for (int i = lo; i < hi; i++) begin
      keys = vecs[i].keys;
      run_cycles(FRAME * vecs[i].frames, p);
      check({vecs[i].name, ".pulses"}, p, vecs[i].exp_pulses);
      check({vecs[i].name, ".code"}, {24'h0, code_out}, {24'h0, vecs[i].exp_code});
      check({vecs[i].name, ".dc"}, {30'h0, digit_count}, {30'h0, vecs[i].exp_dc});
      check({vecs[i].name, ".valid"}, {31'h0, code_valid}, {31'h0, vecs[i].exp_valid});
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, ".col"}, {28'h0, col_select}, 32'h0000_000e);
    check({nm, ".code"}, {24'h0, code_out}, 32'h0);
    check({nm, ".dc"}, {30'h0, digit_count}, 32'h0);
    check({nm, ".valid"}, {31'h0, code_valid}, 32'h0);
    check({nm, ".kp"}, {31'h0, key_pressed}, 32'h0);
  endtask

  initial begin
    int p, tot, s1, s2, s3, s4;
    keys = K_NONE;
    code_ack = 1'b0;
    reset = 1'b1;

    add("t1_4",     K_4,    6, 1, 8'h04, 2'd1, 1'b0);
    add("t1_rel",   K_NONE, 3, 0, 8'h04, 2'd1, 1'b0);
    add("t1_2",     K_2,    6, 1, 8'h42, 2'd2, 1'b0);
    add("t1_rel2",  K_NONE, 3, 0, 8'h42, 2'd2, 1'b0);
    add("t2_hash",  K_HASH, 6, 1, 8'h42, 2'd2, 1'b1);
    add("t2_rel",   K_NONE, 3, 0, 8'h42, 2'd2, 1'b1);
    add("t2_7",     K_7,    6, 1, 8'h42, 2'd2, 1'b1);
    add("t2_rel2",  K_NONE, 3, 0, 8'h42, 2'd2, 1'b1);
    s1 = vecs.size();
    add("t3_A",     K_A,    6, 1, 8'h00, 2'd0, 1'b0);
    add("t3_rel",   K_NONE, 3, 0, 8'h00, 2'd0, 1'b0);
    s2 = vecs.size();
    add("t3_hold5", K_5,   20, 1, 8'h05, 2'd1, 1'b0);
    add("t3_rel2",  K_NONE, 3, 0, 8'h05, 2'd1, 1'b0);
    add("t4_12",    K_1 | K_2, 6, 0, 8'h05, 2'd1, 1'b0);
    add("t4_14",    K_1 | K_4, 6, 0, 8'h05, 2'd1, 1'b0);
    add("t4_9",     K_9,    6, 1, 8'h59, 2'd2, 1'b0);
    add("t4_rel",   K_NONE, 3, 0, 8'h59, 2'd2, 1'b0);
    add("t4_star",  K_STAR, 6, 1, 8'h00, 2'd0, 1'b0);
    add("t4_rel2",  K_NONE, 3, 0, 8'h00, 2'd0, 1'b0);
    add("t4_1",     K_1,    6, 1, 8'h01, 2'd1, 1'b0);
    add("t4_rel3",  K_NONE, 3, 0, 8'h01, 2'd1, 1'b0);
    add("t4_2",     K_2,    6, 1, 8'h12, 2'd2, 1'b0);
    add("t4_rel4",  K_NONE, 3, 0, 8'h12, 2'd2, 1'b0);
    add("t4_3rd",   K_3,    6, 1, 8'h12, 2'd2, 1'b0);
    add("t4_rel5",  K_NONE, 3, 0, 8'h12, 2'd2, 1'b0);
    add("t5_hash",  K_HASH, 6, 1, 8'h12, 2'd2, 1'b1);
    add("t5_rel",   K_NONE, 3, 0, 8'h12, 2'd2, 1'b1);
    s3 = vecs.size();
    add("t5_8",     K_8,    6, 1, 8'h08, 2'd1, 1'b0);
    add("t5_rel2",  K_NONE, 3, 0, 8'h08, 2'd1, 1'b0);
    s4 = vecs.size();
    add("t6_0",     K_0,    6, 1, 8'h80, 2'd2, 1'b0);
    add("t6_rel",   K_NONE, 3, 0, 8'h80, 2'd2, 1'b0);

    // Reset, then release just after an edge so frames end every 16 edges.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    reset = 1'b0;
    run_cycles(4, p);
    check("scan.col1", {28'h0, col_select}, 32'h0000_000d);
    run_cycles(FRAME - 4, p);
    check("scan.col0", {28'h0, col_select}, 32'h0000_000e);

    run_table(0, s1);

    // Ack consumes the code on the next edge.
    code_ack = 1'b1;
    run_cycles(1, p);
    code_ack = 1'b0;
    check("t2_ack.valid", {31'h0, code_valid}, 32'h0);
    check("t2_ack.code", {24'h0, code_out}, 32'h0);
    check("t2_ack.dc", {30'h0, digit_count}, 32'h0);
    run_cycles(FRAME - 1, p);

    run_table(s1, s2);

    // Bouncing '5': alternating frames never build a run.
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? K_5 : K_NONE;
      run_cycles(FRAME, p);
      tot += p;
    end
    check("t3_bounce.pulses", tot, 0);
    check("t3_bounce.code", {24'h0, code_out}, 32'h0);

    run_table(s2, s3);

    // Ack lands on the same edge that accepts '3' in DONE.
    keys = K_3;
    run_cycles(2 * FRAME, p);
    check("t5_pre.pulses", p, 0);
    run_cycles(FRAME - 1, p);
    code_ack = 1'b1;
    run_cycles(1, p);
    code_ack = 1'b0;
    check("t5_coin.kp", {31'h0, key_pressed}, 32'h1);
    check("t5_coin.valid", {31'h0, code_valid}, 32'h0);
    check("t5_coin.code", {24'h0, code_out}, 32'h0);
    check("t5_coin.dc", {30'h0, digit_count}, 32'h0);
    run_cycles(3 * FRAME, p);
    check("t5_hold3.pulses", p, 0);
    check("t5_hold3.dc", {30'h0, digit_count}, 32'h0);
    keys = K_NONE;
    run_cycles(3 * FRAME, p);

    // Ack outside DONE is ignored.
    code_ack = 1'b1;
    run_cycles(1, p);
    code_ack = 1'b0;
    check("t5_ackE.dc", {30'h0, digit_count}, 32'h0);
    check("t5_ackE.valid", {31'h0, code_valid}, 32'h0);
    run_cycles(FRAME - 1, p);

    run_table(s3, s4);

    code_ack = 1'b1;
    run_cycles(1, p);
    code_ack = 1'b0;
    check("t5_ack1.code", {24'h0, code_out}, 32'h0000_0008);
    check("t5_ack1.dc", {30'h0, digit_count}, 32'h1);
    run_cycles(FRAME - 1, p);

    run_table(s4, vecs.size());

    // Reset in FULL with '6' part-way through debounce.
    keys = K_6;
    run_cycles(2 * FRAME, p);
    check("t6_pre.pulses", p, 0);
    check("t6_pre.code", {24'h0, code_out}, 32'h0000_0080);
    run_cycles(5, p);
    reset = 1'b1;
    run_cycles(1, p);
    check_reset_outputs("t6_rst");
    reset = 1'b0;
    run_cycles(2 * FRAME, p);
    check("t6_post2.pulses", p, 0);
    check("t6_post2.dc", {30'h0, digit_count}, 32'h0);
    run_cycles(FRAME, p);
    check("t6_post3.pulses", p, 1);
    check("t6_post3.code", {24'h0, code_out}, 32'h0000_0006);
    check("t6_post3.dc", {30'h0, digit_count}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
